// File: rtl/servo_pkg.sv
// Shared servo link constants, FSM state type and zone helper.
// Used by both the PWM generator and the PWM decoder.
package servo_pkg;

    localparam int unsigned MIN_TICKS     = 50000;
    localparam int unsigned MAX_TICKS     = 100000;
    localparam int unsigned STEP_TICKS    = 196;
    localparam int unsigned FRAME_TICKS   = 1000000;
    localparam int unsigned TIMEOUT_TICKS = 2000000;

    localparam int unsigned WIDTH_W = 17;
    localparam int unsigned SINCE_W = 21;
    localparam int unsigned PRESC_W = 8;
    localparam int unsigned POS_W   = 8;

    localparam logic [POS_W-1:0] ZONE_MID   = 8'd85;
    localparam logic [POS_W-1:0] ZONE_RIGHT = 8'd170;

    typedef enum logic [1:0] {
        WAIT_RISE,
        MEASURE,
        WAIT_FALL
    } state_t;

    typedef struct packed {
        logic left;
        logic mid;
        logic right;
    } zone_t;

    function automatic zone_t zone_of(input logic [POS_W-1:0] pos);
        zone_t z;
        z.left  = (pos < ZONE_MID);
        z.mid   = (pos >= ZONE_MID) && (pos < ZONE_RIGHT);
        z.right = (pos >= ZONE_RIGHT);
        return z;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus registered level with rise/fall strobes.
// Edges are suppressed until the pipeline has refilled after reset.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [1:0] fill_q, fill_d;
    logic       armed;

    // A line already high at reset release must not look like a rise.
    always_comb begin
        armed   = (fill_q == 2'd3);
        s1_d    = din;
        s2_d    = s1_q;
        level_d = s2_q;
        rise_d  = armed && s2_q && !level_q;
        fall_d  = armed && !s2_q && level_q;
        fill_d  = armed ? fill_q : fill_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            fill_q  <= 2'd0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            fill_q  <= fill_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo pulse receiver: measures high time and decodes an 8-bit position.
// Flags out-of-range pulses and loss of signal.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int unsigned MIN_TICKS     = servo_pkg::MIN_TICKS,
    parameter int unsigned MAX_TICKS     = servo_pkg::MAX_TICKS,
    parameter int unsigned STEP_TICKS    = servo_pkg::STEP_TICKS,
    parameter int unsigned TIMEOUT_TICKS = servo_pkg::TIMEOUT_TICKS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [POS_W-1:0] position,
    output logic             pos_valid,
    output logic             pulse_err,
    output logic             timeout,
    output logic             left_check,
    output logic             mid_check,
    output logic             right_check
);

    localparam logic [WIDTH_W-1:0] MIN_W     = WIDTH_W'(MIN_TICKS);
    localparam logic [WIDTH_W-1:0] MAX_W     = WIDTH_W'(MAX_TICKS);
    localparam logic [PRESC_W-1:0] STEP_LAST = PRESC_W'(STEP_TICKS - 1);
    localparam logic [SINCE_W-1:0] TIMEOUT_W = SINCE_W'(TIMEOUT_TICKS);
    localparam logic [POS_W-1:0]   POS_MAX   = '1;

    logic level;
    logic rise;
    logic fall;

    sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    state_t             state_q, state_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [POS_W-1:0]   acc_q, acc_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    zone_t              zone_q, zone_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [SINCE_W-1:0] since_q, since_d;
    logic               timeout_q, timeout_d;

    // timeout is sticky until a rise so it reads 1 straight out of reset.
    always_comb begin
        since_d   = rise ? '0
                  : (since_q == TIMEOUT_W) ? since_q : since_q + 1'b1;
        timeout_d = rise ? 1'b0 : (timeout_q || (since_d == TIMEOUT_W));
    end

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        presc_d = presc_q;
        acc_d   = acc_q;
        pos_d   = pos_q;
        zone_d  = zone_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    state_d = MEASURE;
                    width_d = WIDTH_W'(1);
                    presc_d = '0;
                    acc_d   = '0;
                end
            end
            MEASURE: begin
                if (fall) begin
                    state_d = WAIT_RISE;
                    if (width_q < MIN_W) begin
                        err_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        pos_d   = acc_q;
                        zone_d  = zone_of(acc_q);
                    end
                end else if (level && (width_q == MAX_W)) begin
                    err_d   = 1'b1;
                    state_d = WAIT_FALL;
                end else begin
                    width_d = width_q + 1'b1;
                    // Prescaler stands in for the (W - MIN) / STEP divide.
                    if (width_q >= MIN_W) begin
                        if (presc_q == STEP_LAST) begin
                            presc_d = '0;
                            if (acc_q != POS_MAX) begin
                                acc_d = acc_q + 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + 1'b1;
                        end
                    end
                end
            end
            WAIT_FALL: begin
                if (fall) begin
                    state_d = WAIT_RISE;
                end
            end
            default: state_d = WAIT_RISE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_RISE;
            width_q   <= '0;
            presc_q   <= '0;
            acc_q     <= '0;
            pos_q     <= '0;
            zone_q    <= '{left: 1'b1, mid: 1'b0, right: 1'b0};
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            since_q   <= '0;
            timeout_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            presc_q   <= presc_d;
            acc_q     <= acc_d;
            pos_q     <= pos_d;
            zone_q    <= zone_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            since_q   <= since_d;
            timeout_q <= timeout_d;
        end
    end

    assign position    = pos_q;
    assign pos_valid   = valid_q;
    assign pulse_err   = err_q;
    assign timeout     = timeout_q;
    assign left_check  = zone_q.left;
    assign mid_check   = zone_q.mid;
    assign right_check = zone_q.right;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Directed bench for servo_pwm_decoder with time-scaled tick parameters.
// Scaled: MIN=400, MAX=1200, STEP=3, TIMEOUT=4000, frame=2000.
module tb_servo_pwm_decoder;

    localparam int MIN_T   = 400;
    localparam int MAX_T   = 1200;
    localparam int STEP_T  = 3;
    localparam int TO_T    = 4000;
    localparam int FRAME_T = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_in = 1'b0;
    logic [7:0] position;
    logic       pos_valid;
    logic       pulse_err;
    logic       timeout;
    logic       left_check;
    logic       mid_check;
    logic       right_check;

    servo_pwm_decoder #(
        .MIN_TICKS     (MIN_T),
        .MAX_TICKS     (MAX_T),
        .STEP_TICKS    (STEP_T),
        .TIMEOUT_TICKS (TO_T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .position    (position),
        .pos_valid   (pos_valid),
        .pulse_err   (pulse_err),
        .timeout     (timeout),
        .left_check  (left_check),
        .mid_check   (mid_check),
        .right_check (right_check)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n_valid = 0;
    int n_err = 0;
    int err_high = 0;
    int n_both = 0;
    logic [7:0] last_pos = 8'd0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (pos_valid === 1'b1) begin
            n_valid++;
            last_pos = position;
        end
        if (pulse_err === 1'b1) begin
            n_err++;
            if (pwm_in) err_high++;
        end
        if (pos_valid === 1'b1 && pulse_err === 1'b1) n_both++;
    endtask

    task automatic clr();
        n_valid = 0;
        n_err = 0;
        err_high = 0;
    endtask

    task automatic frame(input int w);
        pwm_in = 1'b1;
        repeat (w) tick();
        pwm_in = 1'b0;
        repeat (FRAME_T - w) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({position, pos_valid, pulse_err} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outs got pos=%0d v=%b e=%b exp 0/0/0",
                     position, pos_valid, pulse_err);
        end
        checks++;
        if ({timeout, left_check, mid_check, right_check} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_flags got %b%b%b%b exp 1100",
                     timeout, left_check, mid_check, right_check);
        end
        rst_n = 1'b1;
        repeat (20) tick();
        checks++;
        if (timeout !== 1'b1 || position !== 8'd0) begin
            failures++;
            $display("FAIL post_reset got to=%b pos=%0d exp 1/0",
                     timeout, position);
        end
    endtask

    task automatic test_frames();
        int       w[7]   = '{400, 800, 1200, 652, 655, 909, 910};
        int       p[7]   = '{0, 133, 255, 84, 85, 169, 170};
        bit [2:0] z[7]   = '{3'b100, 3'b010, 3'b001, 3'b100,
                             3'b010, 3'b010, 3'b001};
        for (int i = 0; i < 7; i++) begin
            clr();
            frame(w[i]);
            checks++;
            if (n_valid !== 1 || n_err !== 0 || last_pos !== 8'(p[i])) begin
                failures++;
                $display("FAIL frame_w%0d got v=%0d e=%0d pos=%0d exp 1/0/%0d",
                         w[i], n_valid, n_err, last_pos, p[i]);
            end
            checks++;
            if ({left_check, mid_check, right_check} !== z[i]
                || position !== 8'(p[i]) || timeout !== 1'b0) begin
                failures++;
                $display("FAIL zone_w%0d got %b%b%b pos=%0d to=%b exp %b/%0d/0",
                         w[i], left_check, mid_check, right_check,
                         position, timeout, z[i], p[i]);
            end
        end
    endtask

    task automatic test_step_boundary();
        int w[4] = '{403, 402, 1165, 1164};
        int p[4] = '{1, 0, 255, 254};
        for (int i = 0; i < 4; i++) begin
            clr();
            frame(w[i]);
            checks++;
            if (n_valid !== 1 || last_pos !== 8'(p[i])) begin
                failures++;
                $display("FAIL step_w%0d got v=%0d pos=%0d exp 1/%0d",
                         w[i], n_valid, last_pos, p[i]);
            end
        end
    endtask

    task automatic test_errors();
        int w[3] = '{399, 1201, 1250};
        clr();
        frame(800);
        for (int i = 0; i < 3; i++) begin
            clr();
            frame(w[i]);
            checks++;
            if (n_err !== 1 || n_valid !== 0 || position !== 8'd133) begin
                failures++;
                $display("FAIL err_w%0d got e=%0d v=%0d pos=%0d exp 1/0/133",
                         w[i], n_err, n_valid, position);
            end
            if (w[i] == 1250) begin
                checks++;
                if (err_high !== 1) begin
                    failures++;
                    $display("FAIL err_while_high got %0d exp 1", err_high);
                end
            end
        end
    endtask

    task automatic test_timeout();
        clr();
        pwm_in = 1'b1;
        repeat (800) tick();
        pwm_in = 1'b0;
        repeat (TO_T + 3 - 800) tick();
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got %b exp 0", timeout);
        end
        tick();
        checks++;
        if (timeout !== 1'b1 || position !== 8'd133 || n_valid !== 1) begin
            failures++;
            $display("FAIL timeout_edge got to=%b pos=%0d v=%0d exp 1/133/1",
                     timeout, position, n_valid);
        end
        repeat (500) tick();
        clr();
        pwm_in = 1'b1;
        repeat (3) tick();
        checks++;
        if (timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_hold got %b exp 1", timeout);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear got %b exp 0", timeout);
        end
        repeat (MIN_T - 4) tick();
        pwm_in = 1'b0;
        repeat (FRAME_T - MIN_T) tick();
        checks++;
        if (n_valid !== 1 || position !== 8'd0 || left_check !== 1'b1) begin
            failures++;
            $display("FAIL timeout_recover got v=%0d pos=%0d l=%b exp 1/0/1",
                     n_valid, position, left_check);
        end
    endtask

    task automatic test_reset_mid_pulse();
        clr();
        frame(1200);
        pwm_in = 1'b1;
        repeat (600) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        clr();
        repeat (300) tick();
        pwm_in = 1'b0;
        repeat (1500) tick();
        checks++;
        if (n_valid !== 0 || n_err !== 0 || position !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid got v=%0d e=%0d pos=%0d exp 0/0/0",
                     n_valid, n_err, position);
        end
        clr();
        frame(800);
        checks++;
        if (n_valid !== 1 || last_pos !== 8'd133 || mid_check !== 1'b1) begin
            failures++;
            $display("FAIL reset_next got v=%0d pos=%0d m=%b exp 1/133/1",
                     n_valid, last_pos, mid_check);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            clr();
            frame((i % 2 == 0) ? MIN_T : MAX_T);
            checks++;
            if (n_valid !== 1 || n_err !== 0
                || last_pos !== ((i % 2 == 0) ? 8'd0 : 8'd255)) begin
                failures++;
                $display("FAIL replay_%0d got v=%0d e=%0d pos=%0d",
                         i, n_valid, n_err, last_pos);
            end
        end
        checks++;
        if (n_both !== 0) begin
            failures++;
            $display("FAIL strobe_overlap got %0d exp 0", n_both);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_step_boundary();
        test_errors();
        test_timeout();
        test_reset_mid_pulse();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
